// File: rtl/playlist_ctrl.sv
// playlist_ctrl: debounced next/prev/play buttons and end-of-song handling
// that drive the song player's index, pause and per-song reset.
module playlist_ctrl #(
   parameter int                   NUM_SLOTS  = 8,
   parameter logic [NUM_SLOTS-1:0] SONG_MASK  = 8'b0000_1101,
   parameter int                   DEB_CYCLES = 20000,
   parameter int                   RST_CYCLES = 4,
   parameter bit                   LOOP       = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_next,
   input  logic       btn_prev,
   input  logic       btn_play,
   input  logic       over,
   output logic [7:0] index,
   output logic       pause,
   output logic       song_rst_n,
   output logic       playing
);

   function automatic logic [7:0] first_slot();
      logic [7:0] r;
      r = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--)
         if (SONG_MASK[i]) r = 8'(i);
      return r;
   endfunction

   function automatic logic [7:0] last_slot();
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < NUM_SLOTS; i++)
         if (SONG_MASK[i]) r = 8'(i);
      return r;
   endfunction

   localparam logic [7:0] FIRST = first_slot();
   localparam logic [7:0] LAST  = last_slot();
   localparam bit         HAS   = |SONG_MASK;

   localparam int DW = $clog2(DEB_CYCLES);
   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
   localparam logic [RW-1:0] RST_MAX = RW'(RST_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, PLAY, PAUSED} state_t;

   state_t        state, state_d;
   logic [7:0]    index_d;
   logic [RW-1:0] rcnt, rcnt_d;

   // bit 0 = next, bit 1 = prev, bit 2 = play
   logic [2:0]    btn_raw, sync1, sync2, deb, deb_q, pulse;
   logic [DW-1:0] cnt [3];
   logic          over_q, over_q2, p_over;

   logic [7:0] nxt, prv, step_idx;
   logic       ev_prev, ev_next, ev_move, ev_over, ev_play;

   assign btn_raw = {btn_play, btn_prev, btn_next};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_q <= '0;
         for (int b = 0; b < 3; b++) cnt[b] <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         deb_q <= deb;
         for (int b = 0; b < 3; b++) begin
            if (sync2[b] == deb[b]) begin
               cnt[b] <= '0;
            end else if (cnt[b] == DEB_MAX) begin
               cnt[b] <= '0;
               deb[b] <= sync2[b];
            end else begin
               cnt[b] <= cnt[b] + 1'b1;
            end
         end
      end
   end

   assign pulse = deb & ~deb_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         over_q  <= 1'b0;
         over_q2 <= 1'b0;
      end else begin
         over_q  <= over;
         over_q2 <= over_q;
      end
   end

   assign p_over = over_q & ~over_q2;

   // Nearest populated slot above/below index; wraps to the extreme slot.
   always_comb begin
      nxt = FIRST;
      prv = LAST;
      for (int i = NUM_SLOTS - 1; i >= 0; i--)
         if (SONG_MASK[i] && (8'(i) > index)) nxt = 8'(i);
      for (int i = 0; i < NUM_SLOTS; i++)
         if (SONG_MASK[i] && (8'(i) < index)) prv = 8'(i);
   end

   assign ev_prev  = HAS && pulse[1];
   assign ev_next  = HAS && pulse[0] && !pulse[1];
   assign ev_move  = ev_prev || ev_next;
   assign ev_over  = HAS && p_over && !pulse[0] && !pulse[1]
                     && song_rst_n && (state == PLAY);
   assign ev_play  = HAS && pulse[2] && !ev_move && !ev_over;
   assign step_idx = ev_prev ? prv : nxt;

   always_comb begin
      state_d = state;
      index_d = index;
      rcnt_d  = rcnt;
      unique case (state)
         IDLE: begin
            if (ev_move) begin
               index_d = step_idx;
            end else if (ev_play) begin
               state_d = LOAD;
               rcnt_d  = '0;
            end
         end
         LOAD: begin
            if (ev_move) begin
               index_d = step_idx;
               rcnt_d  = '0;
            end else if (rcnt == RST_MAX) begin
               state_d = PLAY;
            end else begin
               rcnt_d = rcnt + 1'b1;
            end
         end
         PLAY: begin
            if (ev_move) begin
               index_d = step_idx;
               state_d = LOAD;
               rcnt_d  = '0;
            end else if (ev_over) begin
               if (!LOOP && (nxt <= index)) begin
                  index_d = FIRST;
                  state_d = IDLE;
               end else begin
                  index_d = nxt;
                  state_d = LOAD;
                  rcnt_d  = '0;
               end
            end else if (ev_play) begin
               state_d = PAUSED;
            end
         end
         PAUSED: begin
            if (ev_move) begin
               index_d = step_idx;
               state_d = LOAD;
               rcnt_d  = '0;
            end else if (ev_play) begin
               state_d = PLAY;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         index      <= FIRST;
         rcnt       <= '0;
         pause      <= 1'b1;
         song_rst_n <= 1'b0;
         playing    <= 1'b0;
      end else begin
         state      <= state_d;
         index      <= index_d;
         rcnt       <= rcnt_d;
         pause      <= (state_d != PLAY);
         song_rst_n <= (state_d == PLAY) || (state_d == PAUSED);
         playing    <= (state_d == PLAY);
      end
   end

endmodule

// File: tb/tb_playlist_ctrl.sv
// Bench for playlist_ctrl: two instances (looping and non-looping) driven by
// shared buttons, checked against a settled-state playlist model.
module tb_playlist_ctrl;

   localparam logic [7:0] MASK = 8'b0000_1101;
   localparam int N = 8;
   localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2;
   localparam int A_NEXT = 0, A_PREV = 1, A_PLAY = 2, A_OVER = 3;
   localparam int A_BOTH = 4, A_GLITCH = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn_next = 1'b0, btn_prev = 1'b0, btn_play = 1'b0, over = 1'b0;
   logic [7:0] idx_a, idx_b;
   logic pause_a, pause_b, srn_a, srn_b, play_a, play_b;

   int vectors = 0;
   int errors = 0;

   int mode_a, midx_a, mode_b, midx_b, reloads_exp;

   always #5 clk = ~clk;

   playlist_ctrl #(
      .NUM_SLOTS(8), .SONG_MASK(MASK), .DEB_CYCLES(4),
      .RST_CYCLES(4), .LOOP(1'b1)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_prev(btn_prev),
      .btn_play(btn_play), .over(over), .index(idx_a), .pause(pause_a),
      .song_rst_n(srn_a), .playing(play_a)
   );

   playlist_ctrl #(
      .NUM_SLOTS(8), .SONG_MASK(MASK), .DEB_CYCLES(4),
      .RST_CYCLES(4), .LOOP(1'b0)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_prev(btn_prev),
      .btn_play(btn_play), .over(over), .index(idx_b), .pause(pause_b),
      .song_rst_n(srn_b), .playing(play_b)
   );

   // Length of every song_rst_n low run on instance A that starts from 1.
   int mon_run = 0, mon_done = 0, mon_len = 0;
   logic [7:0] mon_fall_idx = '0;
   logic mon_rise_pause = 1'b1;
   logic prev_srn = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_run = 0;
         prev_srn = 1'b0;
      end else begin
         if (!srn_a && prev_srn) begin
            mon_run = 1;
            mon_fall_idx = idx_a;
         end else if (!srn_a && mon_run > 0) begin
            mon_run++;
         end else if (srn_a && mon_run > 0) begin
            mon_len = mon_run;
            mon_rise_pause = pause_a;
            mon_done++;
            mon_run = 0;
         end
         prev_srn = srn_a;
      end
   end

   function automatic bit has_song(int s);
      logic [7:0] m;
      m = MASK;
      return m[s[2:0]];
   endfunction

   function automatic int m_next(int i);
      for (int d = 1; d <= N; d++)
         if (has_song((i + d) % N)) return (i + d) % N;
      return i;
   endfunction

   function automatic int m_prev(int i);
      for (int d = 1; d <= N; d++)
         if (has_song((i - d + N) % N)) return (i - d + N) % N;
      return i;
   endfunction

   function automatic logic [10:0] expv(int mode, int idx);
      return {8'(idx), mode != M_PLAY, mode != M_IDLE, mode == M_PLAY};
   endfunction

   task automatic check(input string tag, input logic [10:0] got,
                        input logic [10:0] exp);
      vectors++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_one(input int act, input bit loop, inout int mode,
                            inout int idx, output bit reload);
      reload = 1'b0;
      case (act)
         A_NEXT, A_PREV, A_BOTH: begin
            idx = (act == A_NEXT) ? m_next(idx) : m_prev(idx);
            if (mode != M_IDLE) begin
               mode = M_PLAY;
               reload = 1'b1;
            end
         end
         A_PLAY: mode = (mode == M_PLAY) ? M_PAUSE : M_PLAY;
         A_OVER: begin
            if (mode == M_PLAY) begin
               if (!loop && m_next(idx) <= idx) begin
                  idx = m_next(N - 1);
                  mode = M_IDLE;
               end else begin
                  idx = m_next(idx);
                  reload = 1'b1;
               end
            end
         end
         default: ;
      endcase
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit n, input bit p, input bit pl, input int hold);
      btn_next = n;
      btn_prev = p;
      btn_play = pl;
      cycles(hold);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      btn_play = 1'b0;
      cycles(25);
   endtask

   task automatic do_action(input int act);
      int h;
      h = $urandom_range(6, 14);
      case (act)
         A_NEXT: press(1'b1, 1'b0, 1'b0, h);
         A_PREV: press(1'b0, 1'b1, 1'b0, h);
         A_PLAY: press(1'b0, 1'b0, 1'b1, h);
         A_BOTH: press(1'b1, 1'b1, 1'b0, h);
         A_OVER: begin
            over = 1'b1;
            cycles($urandom_range(1, 6));
            over = 1'b0;
            cycles(15);
         end
         default: begin
            btn_next = 1'b1;
            cycles($urandom_range(1, 3));
            btn_next = 1'b0;
            cycles(15);
         end
      endcase
   endtask

   task automatic settle_check(input string tag, input int act);
      bit ra, rb;
      model_one(act, 1'b1, mode_a, midx_a, ra);
      model_one(act, 1'b0, mode_b, midx_b, rb);
      if (ra) reloads_exp++;
      check({tag, " A"}, {idx_a, pause_a, srn_a, play_a}, expv(mode_a, midx_a));
      check({tag, " B"}, {idx_b, pause_b, srn_b, play_b}, expv(mode_b, midx_b));
      check({tag, " reloads"}, 11'(mon_done), 11'(reloads_exp));
      if (ra) begin
         check({tag, " rst_len"}, 11'(mon_len), 11'd4);
         check({tag, " fall_idx"}, 11'(mon_fall_idx), 11'(midx_a));
         check({tag, " rise_pause"}, 11'(mon_rise_pause), 11'd0);
      end
   endtask

   task automatic step(input string tag, input int act);
      do_action(act);
      settle_check(tag, act);
   endtask

   initial begin
      int k;
      int r;
      mode_a = M_IDLE; midx_a = 0;
      mode_b = M_IDLE; midx_b = 0;
      reloads_exp = 0;

      cycles(3);
      rst_n = 1'b1;
      cycles(2);
      check("reset A", {idx_a, pause_a, srn_a, play_a}, {8'd0, 1'b1, 1'b0, 1'b0});
      check("reset B", {idx_b, pause_b, srn_b, play_b}, {8'd0, 1'b1, 1'b0, 1'b0});

      btn_play = 1'b1;
      cycles(10);
      btn_play = 1'b0;
      cycles(25);
      settle_check("play idle", A_PLAY);

      step("next 0->2", A_NEXT);
      step("next 2->3", A_NEXT);
      step("next wrap", A_NEXT);
      step("prev wrap", A_PREV);

      // over rising edge moves the index exactly two edges later
      over = 1'b1;
      cycles(1);
      check("over+1 A", {idx_a, pause_a, srn_a, play_a}, {8'd3, 1'b0, 1'b1, 1'b1});
      cycles(1);
      check("over+2 A", {idx_a, pause_a, srn_a, play_a}, {8'd0, 1'b1, 1'b0, 1'b0});
      cycles(8);
      over = 1'b0;
      cycles(15);
      settle_check("over held", A_OVER);

      step("play toggle", A_PLAY);
      step("over paused", A_OVER);
      step("next+prev", A_BOTH);
      step("glitch", A_GLITCH);

      // async reset while instance A is in LOAD
      btn_prev = 1'b1;
      k = 0;
      while (srn_a && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("reach load", 11'(srn_a), 11'd0);
      #2 rst_n = 1'b0;
      #1;
      check("async rst A", {idx_a, pause_a, srn_a, play_a}, {8'd0, 1'b1, 1'b0, 1'b0});
      check("async rst B", {idx_b, pause_b, srn_b, play_b}, {8'd0, 1'b1, 1'b0, 1'b0});
      btn_prev = 1'b0;
      cycles(4);
      rst_n = 1'b1;
      cycles(20);
      mode_a = M_IDLE; midx_a = 0;
      mode_b = M_IDLE; midx_b = 0;
      settle_check("post rst", A_GLITCH);

      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if (r <= 2) step("rnd next", A_NEXT);
         else if (r <= 4) step("rnd prev", A_PREV);
         else if (r <= 6) step("rnd play", A_PLAY);
         else if (r <= 8) step("rnd over", A_OVER);
         else if ($urandom_range(0, 1) == 0) step("rnd both", A_BOTH);
         else step("rnd glitch", A_GLITCH);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
